// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder.
// master: the requester (drives operands, observes results); slave: the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             i_sub;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;

  modport master (
    output i_start, i_a, i_b, i_cin, i_sub,
    input  o_busy, o_valid, o_sum, o_cout
  );

  modport slave (
    input  i_start, i_a, i_b, i_cin, i_sub,
    output o_busy, o_valid, o_sum, o_cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one FullAdder cell, one bit pair per clock, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN: i_sub=1 computes i_a - i_b
// (b inverted, carry forced to 1); without it i_sub is ignored.

// Single-bit full adder cell used by the serial sequencer.
module FullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_x,
  output logic o_c,
  output logic o_s
);
  assign o_s = i_a ^ i_b ^ i_x;
  assign o_c = (i_a & i_b) | (i_x & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  serial_adder_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] s_sh_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic [WIDTH-1:0] s_sh_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             fa_s;
  logic             fa_c;

  FullAdder u_fa (
    .i_a (a_sh_reg[0]),
    .i_b (b_sh_reg[0]),
    .i_x (carry_reg),
    .o_c (fa_c),
    .o_s (fa_s)
  );

  // Sum register shifts right; the fresh sum bit enters at the MSB so that
  // after WIDTH bits the LSB-first stream sits in natural order.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_sum_shift
      assign s_sh_next[gi] = s_sh_reg[gi + 1];
    end
  endgenerate
  assign s_sh_next[WIDTH-1] = fa_s;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract is a + ~b + 1, so only the loaded B operand and carry change.
  always_comb begin
    b_load     = bus.i_b;
    carry_load = bus.i_cin;
    if (bus.i_sub) begin
      b_load     = ~bus.i_b;
      carry_load = 1'b1;
    end
  end
`else
  logic unused_sub;
  assign unused_sub = bus.i_sub;

  // Add-only build: operands load unchanged.
  always_comb begin
    b_load     = bus.i_b;
    carry_load = bus.i_cin;
  end
`endif

  // Sequencer: accept in IDLE, one bit per RUN cycle, single DONE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      s_sh_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.i_start) begin
            a_sh_reg  <= bus.i_a;
            b_sh_reg  <= b_load;
            carry_reg <= carry_load;
            cnt_reg   <= '0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
          s_sh_reg  <= s_sh_next;
          carry_reg <= fa_c;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            // Results are published only here, never partially.
            sum_reg   <= s_sh_next;
            cout_reg  <= fa_c;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy  = (state_reg != ST_IDLE);
  assign bus.o_valid = (state_reg == ST_DONE);
  assign bus.o_sum   = sum_reg;
  assign bus.o_cout  = cout_reg;

endmodule
